// File: rtl/rd_crc_checker_if.sv
// rtl/rd_crc_checker_if.sv - sampled read beat stream in, forwarded beats and burst status out
interface rd_crc_checker_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] rddata_i;
   logic              rddata_valid_i;
   logic [DATA_W-1:0] dfi_rddata_o;
   logic              dfi_rddata_valid_o;
   logic              burst_done_o;
   logic              crc_err_o;
   logic              abort_o;

   modport master (
      output rddata_i, rddata_valid_i,
      input  dfi_rddata_o, dfi_rddata_valid_o, burst_done_o, crc_err_o, abort_o
   );

   modport slave (
      input  rddata_i, rddata_valid_i,
      output dfi_rddata_o, dfi_rddata_valid_o, burst_done_o, crc_err_o, abort_o
   );
endinterface

// File: rtl/rd_crc_checker.sv
// rtl/rd_crc_checker.sv - read burst tracker with DDR5 CRC-8 check/strip
// Settings are captured on the first beat of a burst; all outputs are registered.
module rd_crc_checker #(
   parameter int DATA_W       = 8,
   parameter int IDLE_TIMEOUT = 16
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            en_i,
   input  logic [1:0]      bl_i,
   input  logic            read_crc_enable_i,
   input  logic            phy_crc_mode_i,
   rd_crc_checker_if.slave bus,
   output logic [7:0]      crc_err_count_o
);
   localparam int GAP_W = $clog2(IDLE_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC0, S_CRC1} state_t;

   state_t            r_state, w_state_nxt;
   logic [1:0]        r_bl, w_bl_nxt;
   logic              r_crc_en, w_crc_en_nxt;
   logic              r_mode, w_mode_nxt;
   logic [5:0]        r_cnt, w_cnt_nxt;
   logic [7:0]        r_crc, w_crc_nxt;
   logic [GAP_W-1:0]  r_gap, w_gap_nxt;
   logic              r_mis0, w_mis0_nxt;
   logic [DATA_W-1:0] r_out_data, w_out_data;
   logic              r_out_valid, w_out_valid;
   logic              r_done, w_done;
   logic              r_err, w_err;
   logic              r_abort, w_abort;
   logic [7:0]        r_err_cnt;
   logic [7:0]        w_crc_base, w_crc_upd;
   logic [5:0]        w_last_idx;
   logic              w_crc_match, w_ff_match;

   // MSB-first CRC-8, poly 0x07, one full beat per call
   function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [DATA_W-1:0] d);
      logic [7:0] c;
      logic       fb;
      c = crc;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         fb = c[7] ^ d[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

   assign w_crc_base  = (r_state == S_IDLE) ? 8'h00 : r_crc;
   assign w_crc_upd   = crc8_upd(w_crc_base, bus.rddata_i);
   assign w_last_idx  = (r_bl == 2'b01) ? 6'd7 : (r_bl == 2'b10) ? 6'd31 : 6'd15;
   assign w_crc_match = (bus.rddata_i == DATA_W'(r_crc));
   assign w_ff_match  = (bus.rddata_i == DATA_W'(8'hFF));

   always_ff @(posedge clk_i) begin
      if (reset_i) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_bl_nxt     = r_bl;
      w_crc_en_nxt = r_crc_en;
      w_mode_nxt   = r_mode;
      w_cnt_nxt    = r_cnt;
      w_crc_nxt    = r_crc;
      w_gap_nxt    = r_gap;
      w_mis0_nxt   = r_mis0;
      w_out_data   = r_out_data;
      w_out_valid  = 1'b0;
      w_done       = 1'b0;
      w_err        = 1'b0;
      w_abort      = 1'b0;
      if (!en_i) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = 6'd0;
         w_gap_nxt   = '0;
      end else if (r_state == S_IDLE) begin
         w_gap_nxt = '0;
         if (bus.rddata_valid_i) begin
            w_bl_nxt     = bl_i;
            w_crc_en_nxt = read_crc_enable_i;
            w_mode_nxt   = phy_crc_mode_i;
            w_crc_nxt    = w_crc_upd;
            w_cnt_nxt    = 6'd1;
            w_out_data   = bus.rddata_i;
            w_out_valid  = 1'b1;
            w_state_nxt  = S_DATA;
         end
      end else if (bus.rddata_valid_i) begin
         w_gap_nxt = '0;
         case (r_state)
            S_DATA: begin
               w_out_data  = bus.rddata_i;
               w_out_valid = 1'b1;
               w_crc_nxt   = w_crc_upd;
               w_cnt_nxt   = r_cnt + 6'd1;
               if (r_cnt == w_last_idx) begin
                  w_cnt_nxt = 6'd0;
                  if (r_crc_en) begin
                     w_state_nxt = S_CRC0;
                  end else begin
                     w_done      = 1'b1;
                     w_state_nxt = S_IDLE;
                  end
               end
            end
            S_CRC0: begin
               w_mis0_nxt  = !w_crc_match;
               w_out_data  = bus.rddata_i;
               w_out_valid = !r_mode;
               w_state_nxt = S_CRC1;
            end
            default: begin
               w_out_data  = bus.rddata_i;
               w_out_valid = !r_mode;
               w_done      = 1'b1;
               w_err       = r_mode && (r_mis0 || !w_ff_match);
               w_state_nxt = S_IDLE;
            end
         endcase
      end else if (r_gap == GAP_W'(IDLE_TIMEOUT - 1)) begin
         w_abort     = 1'b1;
         w_gap_nxt   = '0;
         w_cnt_nxt   = 6'd0;
         w_state_nxt = S_IDLE;
      end else begin
         w_gap_nxt = r_gap + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_bl        <= 2'b00;
         r_crc_en    <= 1'b0;
         r_mode      <= 1'b0;
         r_cnt       <= 6'd0;
         r_crc       <= 8'h00;
         r_gap       <= '0;
         r_mis0      <= 1'b0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_abort     <= 1'b0;
         r_err_cnt   <= 8'd0;
      end else begin
         r_bl        <= w_bl_nxt;
         r_crc_en    <= w_crc_en_nxt;
         r_mode      <= w_mode_nxt;
         r_cnt       <= w_cnt_nxt;
         r_crc       <= w_crc_nxt;
         r_gap       <= w_gap_nxt;
         r_mis0      <= w_mis0_nxt;
         r_out_data  <= w_out_data;
         r_out_valid <= w_out_valid;
         r_done      <= w_done;
         r_err       <= w_err;
         r_abort     <= w_abort;
         if (r_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign bus.dfi_rddata_o       = r_out_data;
   assign bus.dfi_rddata_valid_o = r_out_valid;
   assign bus.burst_done_o       = r_done;
   assign bus.crc_err_o          = r_err;
   assign bus.abort_o            = r_abort;
   assign crc_err_count_o        = r_err_cnt;
endmodule
